// File: rtl/keycode_in_pio_pkg.sv
// keycode_in_pio_pkg
//   Shared definitions for the keycode input PIO: the Avalon register map
//   and the encodings of the EDGE_TYPE parameter.
package keycode_in_pio_pkg;

  // Register offsets on the 2-bit Avalon address bus.
  typedef enum logic [1:0] {
    ADDR_DATA     = 2'd0,
    ADDR_RESERVED = 2'd1,
    ADDR_IRQMASK  = 2'd2,
    ADDR_EDGECAP  = 2'd3
  } reg_addr_e;

  // Capture edge selection for EDGE_TYPE.
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Number of cycles after reset during which edge detection is held off,
  // long enough for the synchronizer and prev stage to fill from zero.
  function automatic int settle_cycles(input int sync_stages);
    return sync_stages + 1;
  endfunction

endpackage

// File: rtl/keycode_in_pio_sync_edge.sv
// pio_sync_edge
//   Synchronizes the asynchronous in_port bus, keeps the previous synchronized
//   value and produces a per-bit edge-select vector. Edge detection is blanked
//   for a short settle window after reset.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   in_port    : asynchronous external input, WIDTH bits
//   sync_q     : synchronized level (last synchronizer stage)
//   sel        : one-cycle pulse per bit on the configured edge
module pio_sync_edge
  import keycode_in_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync_q,
  output logic [WIDTH-1:0] sel
);

  localparam int                SETTLE_CYCLES = settle_cycles(SYNC_STAGES);
  localparam int                CNT_W         = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  SETTLE_DONE   = CNT_W'(SETTLE_CYCLES);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] chain_q, chain_d;
  logic [WIDTH-1:0]                  prev_q, prev_d;
  logic [CNT_W-1:0]                  settle_cnt_q, settle_cnt_d;
  logic                              settled;
  logic [WIDTH-1:0]                  rise, fall, sel_raw;

  assign sync_q = chain_q[SYNC_STAGES-1];

  // Shift chain, settle counter and edge selection. The counter saturates at
  // SETTLE_DONE; until then sel is forced low so the 0 -> level transition
  // of the chain filling after reset is never seen as an edge.
  always_comb begin
    chain_d    = chain_q;
    chain_d[0] = in_port;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      chain_d[i] = chain_q[i-1];
    end
    prev_d = sync_q;

    settled      = (settle_cnt_q == SETTLE_DONE);
    settle_cnt_d = settled ? settle_cnt_q : settle_cnt_q + CNT_W'(1);

    rise = sync_q & ~prev_q;
    fall = ~sync_q & prev_q;
    case (EDGE_TYPE)
      EDGE_FALL: sel_raw = fall;
      EDGE_ANY:  sel_raw = rise | fall;
      default:   sel_raw = rise;
    endcase
    sel = settled ? sel_raw : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      chain_q      <= '0;
      prev_q       <= '0;
      settle_cnt_q <= '0;
    end else begin
      chain_q      <= chain_d;
      prev_q       <= prev_d;
      settle_cnt_q <= settle_cnt_d;
    end
  end

endmodule

// File: rtl/keycode_in_pio.sv
// keycode_in_pio
//   Avalon-MM slave input PIO. Exposes a synchronized WIDTH-bit input bus,
//   an interrupt mask and a write-1-to-clear edge-capture register, and
//   drives a level interrupt when a captured edge is unmasked.
// Ports:
//   clk, reset       : system clock, synchronous active-high reset
//   address          : register select (0 DATA, 1 reserved, 2 IRQMASK, 3 EDGECAP)
//   chipselect       : slave select qualifying read and write_n
//   read, write_n    : read strobe, active-low write strobe
//   writedata        : write data, bits above WIDTH ignored
//   readdata         : registered read data, 1-cycle latency, upper bits 0
//   in_port          : asynchronous external input
//   irq              : active-high level interrupt
module keycode_in_pio
  import keycode_in_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sel;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [WIDTH-1:0] clear_bits;
  logic [31:0]      rd_value;
  logic             wr_en, rd_en;
  reg_addr_e        addr_e;
  logic             unused_wdata;

  // Only the low WIDTH bits of writedata matter.
  assign unused_wdata = ^writedata;

  pio_sync_edge #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_TYPE  (EDGE_TYPE)
  ) u_sync_edge (
    .clk    (clk),
    .reset  (reset),
    .in_port(in_port),
    .sync_q (sync_q),
    .sel    (sel)
  );

  assign addr_e = reg_addr_e'(address);
  assign wr_en  = chipselect & ~write_n;
  assign rd_en  = chipselect & read;

  // Read mux works on the current register contents, so a read in the same
  // cycle as a write returns the value from before the write.
  always_comb begin
    rd_value = '0;
    case (addr_e)
      ADDR_DATA:    rd_value[WIDTH-1:0] = sync_q;
      ADDR_IRQMASK: rd_value[WIDTH-1:0] = irqmask_q;
      ADDR_EDGECAP: rd_value[WIDTH-1:0] = edgecap_q;
      default:      rd_value = '0;
    endcase
  end

  // Register updates. For EDGECAP the new edge is OR-ed in after the clear,
  // so a bit that is cleared and re-detected in the same cycle stays set.
  always_comb begin
    irqmask_d  = irqmask_q;
    clear_bits = '0;
    if (wr_en && addr_e == ADDR_IRQMASK) begin
      irqmask_d = writedata[WIDTH-1:0];
    end
    if (wr_en && addr_e == ADDR_EDGECAP) begin
      clear_bits = writedata[WIDTH-1:0];
    end
    edgecap_d  = (edgecap_q & ~clear_bits) | sel;
    readdata_d = rd_en ? rd_value : readdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
    end else begin
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_keycode_in_pio.sv
// tb_keycode_in_pio
//   Drives two instances of keycode_in_pio (rising-edge and any-edge capture)
//   with identical stimulus. A reference model computes register contents
//   from the history of sampled inputs; expected read data goes into a
//   scoreboard queue that a separate monitor drains as reads complete.
module tb_keycode_in_pio;
  import keycode_in_pio_pkg::*;

  localparam int WIDTH  = 8;
  localparam int SYNC   = 2;
  localparam int MAXCYC = 8192;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        read = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [7:0]  in_port = '0;
  logic [31:0] readdata_rise, readdata_any;
  logic        irq_rise, irq_any;

  always #5 clk = ~clk;

  keycode_in_pio #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .EDGE_TYPE(EDGE_RISE)) dut_rise (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read(read), .write_n(write_n), .writedata(writedata),
    .readdata(readdata_rise), .in_port(in_port), .irq(irq_rise)
  );

  keycode_in_pio #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .EDGE_TYPE(EDGE_ANY)) dut_any (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read(read), .write_n(write_n), .writedata(writedata),
    .readdata(readdata_any), .in_port(in_port), .irq(irq_any)
  );

  // Reference model state
  logic [7:0] hist [0:MAXCYC-1];
  int         edge_no    = 0;
  int         reset_edge = 0;
  bit         model_live = 0;
  logic [7:0] m_mask     = '0;
  logic [7:0] m_cap_rise = '0;
  logic [7:0] m_cap_any  = '0;

  typedef struct {
    logic [31:0] rise_v;
    logic [31:0] any_v;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int passes = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act === exp_v) passes++;
    else $display("[TB] FAIL %s: got %h expected %h (edge %0d)", name, act, exp_v, edge_no);
  endtask

  // Synchronized level after edge e: the in_port sample taken SYNC-1 edges
  // earlier, or 0 if that sample predates the last reset.
  function automatic logic [7:0] data_after(input int e);
    if (e - SYNC + 1 <= reset_edge) return 8'h00;
    return hist[e - SYNC + 1];
  endfunction

  function automatic logic [31:0] reg_value(input logic [1:0] a, input logic [7:0] s, input logic [7:0] cap);
    case (a)
      2'd0:    return {24'h0, s};
      2'd2:    return {24'h0, m_mask};
      2'd3:    return {24'h0, cap};
      default: return 32'h0;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs present at it.
  task automatic modelEdge();
    logic [7:0] s_now, s_prev, rise, fall, clr;
    bit settled;
    if (reset) begin
      reset_edge = edge_no;
      m_mask     = '0;
      m_cap_rise = '0;
      m_cap_any  = '0;
      model_live = 1;
      return;
    end
    s_now   = data_after(edge_no - 1);
    s_prev  = data_after(edge_no - 2);
    settled = ((edge_no - 1) - reset_edge) >= SYNC + 1;
    rise    = settled ? (s_now & ~s_prev) : 8'h00;
    fall    = settled ? (~s_now & s_prev) : 8'h00;
    if (chipselect && read)
      sb.push_back('{rise_v: reg_value(address, s_now, m_cap_rise),
                     any_v:  reg_value(address, s_now, m_cap_any)});
    clr = 8'h00;
    if (chipselect && !write_n) begin
      if (address == 2'd2) m_mask = writedata[7:0];
      if (address == 2'd3) clr = writedata[7:0];
    end
    m_cap_rise = (m_cap_rise & ~clr) | rise;
    m_cap_any  = (m_cap_any & ~clr) | rise | fall;
  endtask

  // One clock: inputs are already driven; update the model at the edge and
  // return at the following falling edge.
  task automatic applyStimulus();
    @(posedge clk);
    edge_no++;
    hist[edge_no] = in_port;
    modelEdge();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    chipselect = 0; read = 0; write_n = 1;
    repeat (n) applyStimulus();
  endtask

  task automatic do_read(input logic [1:0] a);
    chipselect = 1; read = 1; write_n = 1; address = a;
    applyStimulus();
    chipselect = 0; read = 0;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1; read = 0; write_n = 0; address = a; writedata = d;
    applyStimulus();
    chipselect = 0; write_n = 1;
  endtask

  // Monitor: irq every cycle, readdata one cycle after each accepted read.
  initial begin
    bit   rd_now;
    exp_t e;
    forever begin
      @(posedge clk);
      rd_now = chipselect & read & ~reset;
      @(negedge clk);
      if (model_live) begin
        checkOutput("irq_rise", {31'h0, irq_rise}, {31'h0, |(m_cap_rise & m_mask)});
        checkOutput("irq_any",  {31'h0, irq_any},  {31'h0, |(m_cap_any & m_mask)});
        if (rd_now) begin
          if (sb.size() == 0) begin
            checkOutput("scoreboard_empty", 32'h1, 32'h0);
          end else begin
            e = sb.pop_front();
            checkOutput("readdata_rise", readdata_rise, e.rise_v);
            checkOutput("readdata_any",  readdata_any,  e.any_v);
          end
        end
      end
    end
  end

  initial begin
    // Reset with inputs high: the settle window must hide the fill edge.
    in_port = 8'hFF;
    reset = 1;
    idle(3);
    reset = 0;
    idle(10);
    do_read(2'd3);
    do_read(2'd0);
    do_read(2'd1);

    // Rising edge on bit 0 with it unmasked.
    in_port = 8'h00;
    idle(5);
    do_write(2'd3, 32'hFFFF_FFFF);
    do_write(2'd2, 32'h0000_0001);
    in_port = 8'h01;
    idle(4);
    do_read(2'd3);

    // Clear it, then read back.
    do_write(2'd3, 32'h0000_0001);
    do_read(2'd3);
    do_read(2'd0);
    do_read(2'd2);

    // Bit 2 rises; the clear of bit 2 lands in the same cycle as its sel.
    in_port = 8'h05;
    idle(2);
    do_write(2'd3, 32'h0000_0004);
    do_read(2'd3);

    // Bit 7 toggled twice with everything masked, then unmasked.
    idle(3);
    do_write(2'd2, 32'h0);
    do_write(2'd3, 32'hFF);
    in_port = 8'h85;
    idle(3);
    in_port = 8'h05;
    idle(3);
    do_read(2'd3);
    do_write(2'd2, 32'h80);
    idle(1);

    // Read and write in the same cycle returns the old value.
    chipselect = 1; read = 1; write_n = 0; address = 2'd2; writedata = 32'h3C;
    applyStimulus();
    idle(1);
    do_read(2'd2);

    // Fill all captures and the mask, then reset with a write pending.
    do_write(2'd2, 32'hFF);
    in_port = 8'h00;
    idle(3);
    in_port = 8'hFF;
    idle(4);
    do_read(2'd3);
    reset = 1; chipselect = 1; write_n = 0; address = 2'd2; writedata = 32'h55;
    applyStimulus();
    reset = 0; chipselect = 0; write_n = 1;
    do_read(2'd2);
    do_read(2'd3);
    idle(6);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) in_port = 8'($urandom);
      chipselect = 1'($urandom_range(0, 1));
      read       = 1'($urandom_range(0, 1));
      write_n    = 1'($urandom_range(0, 2) != 0);
      address    = 2'($urandom_range(0, 3));
      writedata  = $urandom;
      reset      = ($urandom_range(0, 99) == 0);
      applyStimulus();
    end
    reset = 0;
    idle(3);

    checkOutput("scoreboard_drained", sb.size(), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/keycode_in_pio.md
Name: keycode_in_pio

Overview:
- Avalon-MM slave input port: the CPU-read counterpart of the keycode output PIO.
- Samples an external WIDTH-bit bus (keyboard/status lines from the FPGA fabric) through a synchronizer.
- Exposes the synchronized level plus a per-bit edge-capture register.
- Raises a maskable level interrupt to the Nios II when a selected edge occurs.

Parameters:
- WIDTH, 8, width of in_port and of all data/mask/capture registers (1..32)
- SYNC_STAGES, 2, synchronizer flop count (2..4)
- EDGE_TYPE, 0, capture edge: 0 = rising, 1 = falling, 2 = any

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- address  in  2  register select
- chipselect  in  1  slave select
- read  in  1  read strobe, qualified by chipselect
- write_n  in  1  active-low write strobe, qualified by chipselect
- writedata  in  32  write data; bits above WIDTH ignored
- readdata  out  32  registered read data; bits above WIDTH read 0
- in_port  in  WIDTH  asynchronous external input
- irq  out  1  level interrupt, active-high

Behaviour:
- Register map:
  - addr 0: DATA (RO, synchronized in_port)
  - addr 1: reserved (reads 0, writes ignored)
  - addr 2: IRQMASK (RW)
  - addr 3: EDGECAP (read; write-1-to-clear per bit)
- Synchronizer:
  - in_port passes through SYNC_STAGES flops; the last stage is sync_q.
  - prev_q <= sync_q every cycle.
  - A level change at in_port sampled on edge k is visible in DATA after edge k+SYNC_STAGES-1.
- Edge detection:
  - rise = sync_q & ~prev_q; fall = ~sync_q & prev_q; sel = rise, fall, or rise|fall per EDGE_TYPE.
  - EDGECAP[i] <= 1 on the clock after sel[i]=1.
- Write-1-to-clear:
  - A write to addr 3 clears every bit set in writedata[WIDTH-1:0].
  - If the same bit has sel=1 in the same cycle, set wins: the bit ends at 1.
- Settle window:
  - After reset deasserts, a counter runs for SYNC_STAGES+1 cycles.
  - While it runs, sel is forced to 0, so no spurious edge is captured while the chain fills from 0.
  - This counter is the only post-reset state; it saturates and stays "settled".
- irq = |(EDGECAP & IRQMASK), combinational from registers, no extra latency.
- Reads:
  - When chipselect & read in cycle c, readdata is updated at edge c and holds that value until the next read.
  - Read latency is 1 cycle.
  - Reads have no side effects (reading EDGECAP does not clear it).
- Writes:
  - Occur when chipselect & ~write_n.
  - Writes to addr 0/1 are ignored.
  - Write and read strobes together: the write takes effect; readdata returns the pre-write value.
- Reset:
  - Clears synchronizer flops, prev_q, IRQMASK, EDGECAP, readdata, and the settle counter.
  - After reset, irq = 0 and readdata = 0.
  - A reset asserted mid-operation overrides everything on the same edge, including a pending write.

Decomposition:
- Shared package:
  - register address constants (ADDR_DATA=0, ADDR_IRQMASK=2, ADDR_EDGECAP=3)
  - EDGE_RISE/EDGE_FALL/EDGE_ANY encodings
- Sub-module: pio_sync_edge holds the synchronizer, prev_q, settle counter and edge select, and outputs sync_q and sel.
- The top level holds the register file, read mux and irq.

Test Plan:
- Reset with in_port=8'hFF held high, wait 10 cycles -> EDGECAP reads 0 (settle window suppressed the edge); DATA reads 8'hFF; irq=0.
- EDGE_TYPE=0, IRQMASK=8'h01, in_port 0->8'h01 at edge k -> irq rises after edge k+SYNC_STAGES; EDGECAP reads 8'h01.
- Write 8'h01 to addr 3 -> irq falls the next cycle; EDGECAP reads 0; DATA still 8'h01.
- in_port bit 2 rises so that sel[2]=1 in the same cycle as a write of 8'h04 to addr 3 -> EDGECAP[2]=1 afterwards (set wins).
- EDGE_TYPE=2, IRQMASK=0, toggle in_port bit 7 twice -> EDGECAP=8'h80, irq stays 0; then write IRQMASK=8'h80 -> irq=1 the next cycle.
- Assert reset mid-stream with EDGECAP=8'hFF, IRQMASK=8'hFF, and a write pending -> on the next edge all registers are 0 and irq=0; the pending write is lost.
